// File: rtl/qlm_pkg.sv
// qlm_pkg: shared width helpers and default sizing for the quantised-log multiplier.
package qlm_pkg;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   localparam int DEF_W = 8;
   localparam int DEF_Q = 2;
   localparam int DEF_TAG_W = 4;
   localparam int DEF_K = clog2(DEF_W);
   localparam int DEF_LOGW = DEF_K + DEF_Q;
endpackage

// File: rtl/qlm_log_enc.sv
// qlm_log_enc: leading-one position and Q-bit fraction of an unsigned magnitude.
module qlm_log_enc
   import qlm_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int Q = DEF_Q,
   parameter int K = clog2(W)
) (
   input  logic [W-1:0] i_a,
   output logic [K-1:0] o_k,
   output logic [Q-1:0] o_f,
   output logic         o_zero
);
   always_comb begin
      o_k = '0;
      for (int i = 0; i < W; i++) if (i_a[i]) o_k = K'(i);
   end
   // Q bits just below the leading one; zeros shift in when the leading one sits low
   assign o_f    = Q'({i_a, {Q{1'b0}}} >> o_k);
   assign o_zero = ~|i_a;
endmodule

// File: rtl/qlm_pipe_mult.sv
// qlm_pipe_mult: 3-stage streaming Mitchell-style signed log multiplier with valid/ready
// back-pressure and a pass-through tag.
module qlm_pipe_mult
   import qlm_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int Q     = DEF_Q,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_x,
   input  logic [W-1:0]     in_y,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_p,
   output logic [TAG_W-1:0] out_tag
);
   localparam int K    = clog2(W);
   localparam int LOGW = K + Q;

   logic             r_v1, r_v2, r_v3;
   logic [LOGW-1:0]  r_lx, r_ly;
   logic             r_s1, r_z1, r_s2, r_z2;
   logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
   logic [LOGW:0]    r_ls;
   logic [2*W-1:0]   r_p;

   logic             w_rdy2, w_rdy3;
   logic [W-1:0]     w_ax, w_ay;
   logic [K-1:0]     w_kx, w_ky;
   logic [Q-1:0]     w_fx, w_fy;
   logic             w_zx, w_zy;
   logic [K:0]       w_kp;
   logic [Q-1:0]     w_fp;
   logic [2*W-1:0]   w_mag, w_p;

   assign w_rdy3    = ~r_v3 | out_ready;
   assign w_rdy2    = ~r_v2 | w_rdy3;
   assign in_ready  = ~r_v1 | w_rdy2;
   assign out_valid = r_v3;
   assign out_p     = r_p;
   assign out_tag   = r_tag3;

   assign w_ax = in_x ^ {W{in_x[W-1]}};
   assign w_ay = in_y ^ {W{in_y[W-1]}};

   qlm_log_enc #(.W(W), .Q(Q), .K(K)) u_enc_x (.i_a(w_ax), .o_k(w_kx), .o_f(w_fx), .o_zero(w_zx));
   qlm_log_enc #(.W(W), .Q(Q), .K(K)) u_enc_y (.i_a(w_ay), .o_k(w_ky), .o_f(w_fy), .o_zero(w_zy));

   // Antilog on a word widened by Q so the implicit leading one never falls off before the >>Q
   assign w_kp  = r_ls[LOGW:Q];
   assign w_fp  = r_ls[Q-1:0];
   assign w_mag = (2*W)'(({{(2*W-1){1'b0}}, 1'b1, w_fp} << w_kp) >> Q);
   assign w_p   = r_z2 ? '0 : w_mag ^ {(2*W){r_s2}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_v3   <= 1'b0;
         r_lx   <= '0;
         r_ly   <= '0;
         r_s1   <= 1'b0;
         r_z1   <= 1'b0;
         r_tag1 <= '0;
         r_ls   <= '0;
         r_s2   <= 1'b0;
         r_z2   <= 1'b0;
         r_tag2 <= '0;
         r_p    <= '0;
         r_tag3 <= '0;
      end else begin
         if (in_ready) r_v1 <= in_valid;
         if (in_ready && in_valid) begin
            r_lx   <= {w_kx, w_fx};
            r_ly   <= {w_ky, w_fy};
            r_s1   <= in_x[W-1] ^ in_y[W-1];
            r_z1   <= w_zx | w_zy;
            r_tag1 <= in_tag;
         end
         if (w_rdy2) r_v2 <= r_v1;
         if (w_rdy2 && r_v1) begin
            r_ls   <= {1'b0, r_lx} + {1'b0, r_ly};
            r_s2   <= r_s1;
            r_z2   <= r_z1;
            r_tag2 <= r_tag1;
         end
         if (w_rdy3) r_v3 <= r_v2;
         if (w_rdy3 && r_v2) begin
            r_p    <= w_p;
            r_tag3 <= r_tag2;
         end
      end
   end
endmodule
